// File: rtl/sv39_mmu_tlb_pkg.sv
// Shared types for the Sv39 translation unit: cbus request/response, satp, PTE, TLB entry.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package sv39_mmu_tlb_pkg;

    localparam int PAGE_SHIFT = 12;
    localparam int VPN_BITS   = 9;
    localparam int PPN_W      = 44;
    localparam int VPN_W      = 27;
    localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } mburst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        mburst_t     burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef struct packed {
        logic [3:0]       mode;
        logic [15:0]      asid;
        logic [PPN_W-1:0] ppn;
    } satp_t;

    typedef struct packed {
        logic [9:0]       reserved;
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rsw;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_t;

    // level: 0 = 4 KiB, 1 = 2 MiB, 2 = 1 GiB
    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
        logic [1:0]       level;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WALK  = 3'd1,
        S_CHECK = 3'd2,
        S_PASS  = 3'd3,
        S_FAULT = 3'd4
    } mmu_state_t;

    // VPN bits that must match for an entry of the given level.
    function automatic logic [VPN_W-1:0] vpn_mask(input logic [1:0] level);
        case (level)
            2'd2:    return 27'h7FC_0000;
            2'd1:    return 27'h7FF_FE00;
            default: return 27'h7FF_FFFF;
        endcase
    endfunction

    // One 9-bit VPN field out of vaddr[38:12].
    function automatic logic [VPN_BITS-1:0] vpn_slice(input logic [VPN_W-1:0] vpn,
                                                      input logic [1:0] lvl);
        case (lvl)
            2'd2:    return vpn[26:18];
            2'd1:    return vpn[17:9];
            default: return vpn[8:0];
        endcase
    endfunction

    // Superpage leaves take their low PPN fields from the virtual address.
    function automatic logic [63:0] make_paddr(input logic [PPN_W-1:0] ppn,
                                               input logic [1:0] level,
                                               input logic [29:0] vaddr);
        logic [PPN_W-1:0] p;
        p = ppn;
        if (level >= 2'd1) p[8:0]  = vaddr[20:12];
        if (level >= 2'd2) p[17:9] = vaddr[29:21];
        return {8'b0, p, vaddr[11:0]};
    endfunction

endpackage

// File: rtl/sv39_mmu_tlb_tlb.sv
// Fully-associative TLB: combinational lookup, fill into first free slot or round-robin victim.
// Latency: lookup 0 cycles; fill/flush take effect on the next clock edge.
// Backpressure: none; flush has priority over a fill in the same cycle.
// Ports: lookup_vaddr -> hit/paddr; fill_* write one entry; flush clears all valid bits.
module mmu_tlb
    import sv39_mmu_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [38:0]      lookup_vaddr,
    output logic             hit,
    output logic [63:0]      paddr,
    input  logic             fill,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [PPN_W-1:0] fill_ppn,
    input  logic [1:0]       fill_level,
    input  logic             flush
);

    localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    tlb_entry_t       entries [TLB_ENTRIES];
    logic [IDX_W-1:0] victim;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic [IDX_W-1:0] fill_idx;
    logic [VPN_W-1:0] lookup_vpn;

    assign lookup_vpn = lookup_vaddr[38:12];

    // Scan downwards so the lowest-index match wins.
    always_comb begin
        hit   = 1'b0;
        paddr = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (entries[i].valid &&
                ((entries[i].vpn & vpn_mask(entries[i].level)) ==
                 (lookup_vpn & vpn_mask(entries[i].level)))) begin
                hit   = 1'b1;
                paddr = make_paddr(entries[i].ppn, entries[i].level, lookup_vaddr[29:0]);
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign fill_idx = free_found ? free_idx : victim;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            victim <= '0;
        end else if (flush) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (fill) begin
            entries[fill_idx] <= '{valid: 1'b1, vpn: fill_vpn, ppn: fill_ppn, level: fill_level};
            // Pointer moves on every fill, even one that landed in a free slot.
            if (victim == IDX_W'(TLB_ENTRIES - 1)) begin
                victim <= '0;
            end else begin
                victim <= victim + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sv39_mmu_tlb.sv
// Sv39 translation between pipeline port (ireq/iresp) and memory (oreq/oresp) with TLB and walker.
// Latency: bypass 0 cycles; TLB hit 1 bubble cycle; miss 2 cycles per PTE level plus the access.
// Backpressure: iresp mirrors oresp in bypass/PASS; walker waits on oresp.ready && oresp.last.
// Ports: satp/priviledgeMode select translation; sfence flushes; page_fault/fault_vaddr report faults.
module sv39_mmu_tlb
    import sv39_mmu_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES   = 8,
    parameter int FLUSH_ON_SATP = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  cbus_req_t   ireq,
    output cbus_resp_t  iresp,
    output cbus_req_t   oreq,
    input  cbus_resp_t  oresp,
    input  satp_t       satp,
    input  logic [1:0]  priviledgeMode,
    input  logic        sfence,
    output logic        page_fault,
    output logic [63:0] fault_vaddr
);

    mmu_state_t  state;
    cbus_req_t   req_q;
    logic [63:0] paddr_q;
    logic [63:0] pte_addr;
    logic [1:0]  lvl;
    pte_t        pte_q;
    logic        kill;
    logic [63:0] fault_vaddr_q;
    satp_t       satp_q;

    logic        active;
    logic        satp_chg;
    logic        flush;
    logic        tlb_hit;
    logic [63:0] tlb_paddr;
    logic        pte_bad;
    logic        pte_leaf;
    logic        misaligned;
    logic        to_fault;
    logic        do_fill;
    logic        pte_unused;

    assign active   = (satp.mode == SATP_MODE_SV39) && (priviledgeMode != 2'b11);
    assign satp_chg = (FLUSH_ON_SATP != 0) && (satp != satp_q);
    assign flush    = sfence || satp_chg;

    // U/A/D/G are left to the pipeline.
    assign pte_unused = ^{pte_q.reserved, pte_q.rsw, pte_q.d, pte_q.a, pte_q.g, pte_q.u};

    assign pte_bad    = !pte_q.v || (!pte_q.r && pte_q.w);
    assign pte_leaf   = pte_q.r || pte_q.x;
    assign misaligned = ((lvl == 2'd1) && (|pte_q.ppn[8:0])) ||
                        ((lvl == 2'd2) && (|pte_q.ppn[17:0]));
    assign to_fault   = (state == S_CHECK) &&
                        (pte_bad || (pte_leaf && misaligned) || (!pte_leaf && lvl == 2'd0));
    // A flush seen during the walk (kill) drops the fill but not the translation.
    assign do_fill    = (state == S_CHECK) && !pte_bad && pte_leaf && !misaligned && !kill;

    mmu_tlb #(
        .TLB_ENTRIES (TLB_ENTRIES)
    ) u_tlb (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_vaddr (ireq.addr[38:0]),
        .hit          (tlb_hit),
        .paddr        (tlb_paddr),
        .fill         (do_fill),
        .fill_vpn     (req_q.addr[38:12]),
        .fill_ppn     (pte_q.ppn),
        .fill_level   (lvl),
        .flush        (flush)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            req_q         <= '0;
            paddr_q       <= '0;
            pte_addr      <= '0;
            lvl           <= 2'd0;
            pte_q         <= '0;
            kill          <= 1'b0;
            fault_vaddr_q <= '0;
            satp_q        <= '0;
        end else begin
            satp_q <= satp;
            if (flush && (state == S_WALK || state == S_CHECK)) begin
                kill <= 1'b1;
            end
            if (to_fault) begin
                fault_vaddr_q <= req_q.addr;
            end
            case (state)
                S_IDLE: begin
                    if (ireq.valid && active) begin
                        req_q <= ireq;
                        if (tlb_hit) begin
                            paddr_q <= tlb_paddr;
                            state   <= S_PASS;
                        end else begin
                            lvl      <= 2'd2;
                            kill     <= 1'b0;
                            pte_addr <= {8'b0, satp.ppn, 12'b0} +
                                        {52'b0, vpn_slice(ireq.addr[38:12], 2'd2), 3'b0};
                            state    <= S_WALK;
                        end
                    end
                end
                S_WALK: begin
                    if (oresp.ready && oresp.last) begin
                        pte_q <= pte_t'(oresp.data);
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (to_fault) begin
                        state <= S_FAULT;
                    end else if (pte_leaf) begin
                        paddr_q <= make_paddr(pte_q.ppn, lvl, req_q.addr[29:0]);
                        state   <= S_PASS;
                    end else begin
                        lvl      <= lvl - 2'd1;
                        pte_addr <= {8'b0, pte_q.ppn, 12'b0} +
                                    {52'b0, vpn_slice(req_q.addr[38:12], lvl - 2'd1), 3'b0};
                        state    <= S_WALK;
                    end
                end
                S_PASS: begin
                    if (!ireq.valid || (oresp.ready && oresp.last)) begin
                        state <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decode straight from registered state; nothing leaks out while in reset.
    always_comb begin
        oreq  = '0;
        iresp = '0;
        if (reset_n) begin
            case (state)
                S_IDLE: begin
                    if (!active) begin
                        oreq  = ireq;
                        iresp = oresp;
                    end
                end
                S_WALK: begin
                    oreq.valid    = 1'b1;
                    oreq.is_write = 1'b0;
                    oreq.addr     = pte_addr;
                    oreq.size     = MSIZE8;
                    oreq.strobe   = 8'hFF;
                    oreq.len      = MLEN1;
                    oreq.burst    = BURST_FIXED;
                end
                S_PASS: begin
                    oreq       = req_q;
                    oreq.addr  = paddr_q;
                    // An abandoned request must not reach memory.
                    oreq.valid = req_q.valid && ireq.valid;
                    iresp      = oresp;
                end
                S_FAULT: begin
                    iresp.ready = 1'b1;
                    iresp.last  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign page_fault  = (state == S_FAULT);
    assign fault_vaddr = fault_vaddr_q;

endmodule

// File: tb/tb_sv39_mmu_tlb.sv
// Directed bench for sv39_mmu_tlb with a page-table memory model answering in the same cycle.
// Latency: n/a.
// Backpressure: memory model always ready.
module tb_sv39_mmu_tlb;
    import sv39_mmu_tlb_pkg::*;

    logic        clk;
    logic        reset_n;
    cbus_req_t   ireq;
    cbus_resp_t  iresp;
    cbus_req_t   oreq;
    cbus_resp_t  oresp;
    satp_t       satp;
    logic [1:0]  priv;
    logic        sfence;
    logic        page_fault;
    logic [63:0] fault_vaddr;

    logic        mem_auto;
    cbus_resp_t  oresp_man;
    logic [63:0] pt_a [32];
    logic [63:0] pt_d [32];
    int          pt_n = 0;
    logic [63:0] pte_log [$];

    int n_checks = 0;
    int n_fail   = 0;

    sv39_mmu_tlb #(
        .TLB_ENTRIES   (8),
        .FLUSH_ON_SATP (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ireq           (ireq),
        .iresp          (iresp),
        .oreq           (oreq),
        .oresp          (oresp),
        .satp           (satp),
        .priviledgeMode (priv),
        .sfence         (sfence),
        .page_fault     (page_fault),
        .fault_vaddr    (fault_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < pt_n; i++) begin
            if (pt_a[i] == a) d = pt_d[i];
        end
        return d;
    endfunction

    always_comb begin
        oresp = oresp_man;
        if (mem_auto) begin
            oresp.ready = oreq.valid;
            oresp.last  = oreq.valid;
            oresp.data  = oreq.valid ? mem_rd(oreq.addr) : 64'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pt_set(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < pt_n; i++) begin
            if (pt_a[i] == a) begin
                pt_d[i] = d;
                return;
            end
        end
        pt_a[pt_n] = a;
        pt_d[pt_n] = d;
        pt_n++;
    endtask

    function automatic logic [63:0] nonleaf(input logic [43:0] ppn);
        return {10'b0, ppn, 10'h001};
    endfunction

    function automatic logic [63:0] leaf(input logic [43:0] ppn);
        return {10'b0, ppn, 10'h00F};
    endfunction

    // Called #1 after a posedge; returns #1 after the posedge that ends the request.
    task automatic access(input logic [63:0] va, output logic [63:0] pa, output int lat,
                          output logic flt);
        logic done;
        pte_log.delete();
        pa   = '0;
        lat  = 0;
        flt  = 1'b0;
        done = 1'b0;
        ireq        = '0;
        ireq.valid  = 1'b1;
        ireq.addr   = va;
        ireq.size   = MSIZE8;
        ireq.strobe = 8'hFF;
        ireq.len    = MLEN1;
        ireq.burst  = BURST_FIXED;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (iresp.ready && iresp.last) begin
                done = 1'b1;
                lat  = cyc;
                flt  = page_fault;
                if (oreq.valid) pa = oreq.addr;
            end else if (oreq.valid) begin
                pte_log.push_back(oreq.addr);
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("timeout", 64'd0, 64'd1);
        ireq.valid = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [63:0] va, input int n_pte,
                             input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2,
                             input logic [63:0] exp_pa, input int exp_lat, input logic exp_flt);
        logic [63:0] pa;
        int          lat;
        logic        flt;
        logic [63:0] exp_p [3];
        exp_p[0] = p0;
        exp_p[1] = p1;
        exp_p[2] = p2;
        access(va, pa, lat, flt);
        check({tag, ".npte"}, 64'(pte_log.size()), 64'(n_pte));
        for (int i = 0; i < n_pte && i < pte_log.size(); i++) begin
            check($sformatf("%s.pte%0d", tag, i), pte_log[i], exp_p[i]);
        end
        check({tag, ".pa"}, pa, exp_pa);
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".fault"}, 64'(flt), 64'(exp_flt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        ireq      = '0;
        satp      = '{mode: 4'd8, asid: 16'd0, ppn: 44'h80000};
        priv      = 2'b11;
        sfence    = 1'b0;
        mem_auto  = 1'b1;
        oresp_man = '0;

        pt_set(64'h8000_0000, nonleaf(44'h80001));
        pt_set(64'h8000_1010, nonleaf(44'h80002));
        pt_set(64'h8000_2010, leaf(44'h80123));
        pt_set(64'h8000_1018, leaf(44'h80201));
        for (int i = 0; i < 9; i++) begin
            pt_set(64'h8000_2080 + 64'(i * 8), leaf(44'h90000 + 44'(i)));
        end

        // Reset: outputs held at zero even with a request presented in bypass mode.
        ireq.valid = 1'b1;
        ireq.addr  = 64'h1234;
        #2;
        check("rst.oreq_valid", 64'(oreq.valid), 64'd0);
        check("rst.oreq_addr", oreq.addr, 64'd0);
        check("rst.iresp_ready", 64'(iresp.ready), 64'd0);
        check("rst.page_fault", 64'(page_fault), 64'd0);
        check("rst.fault_vaddr", fault_vaddr, 64'd0);
        ireq = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Bypass in M mode: combinational pass-through both directions.
        mem_auto         = 1'b0;
        oresp_man.ready  = 1'b1;
        oresp_man.last   = 1'b1;
        oresp_man.data   = 64'hDEAD_BEEF_0000_0001;
        ireq.valid       = 1'b1;
        ireq.addr        = 64'h8000_1000;
        #1;
        check("byp.oreq_valid", 64'(oreq.valid), 64'd1);
        check("byp.oreq_addr", oreq.addr, 64'h8000_1000);
        check("byp.iresp_data", iresp.data, 64'hDEAD_BEEF_0000_0001);
        check("byp.iresp_last", 64'(iresp.last), 64'd1);
        ireq     = '0;
        mem_auto = 1'b1;
        priv     = 2'b01;
        @(posedge clk);
        #1;

        run_check("walk4k", 64'h0040_2123, 3, 64'h8000_0000, 64'h8000_1010, 64'h8000_2010,
                  64'h8012_3123, 8, 1'b0);
        run_check("hit4k", 64'h0040_2FF0, 0, 0, 0, 0, 64'h8012_3FF0, 2, 1'b0);

        run_check("mis2m", 64'h0060_0ABC, 2, 64'h8000_0000, 64'h8000_1018, 0, 64'h0, 6, 1'b1);
        check("mis2m.fault_vaddr", fault_vaddr, 64'h0060_0ABC);
        @(negedge clk);
        check("mis2m.pulse", 64'(page_fault), 64'd0);
        @(posedge clk);
        #1;
        pt_set(64'h8000_1018, leaf(44'h80200));
        run_check("walk2m", 64'h0060_0ABC, 2, 64'h8000_0000, 64'h8000_1018, 0,
                  64'h8020_0ABC, 6, 1'b0);
        run_check("hit2m", 64'h007F_F123, 0, 0, 0, 0, 64'h803F_F123, 2, 1'b0);

        run_check("inv1", 64'h4000_0123, 1, 64'h8000_0008, 0, 0, 64'h0, 4, 1'b1);
        check("inv1.fault_vaddr", fault_vaddr, 64'h4000_0123);
        run_check("inv2", 64'h4000_0123, 1, 64'h8000_0008, 0, 0, 64'h0, 4, 1'b1);
        check("inv2.fault_vaddr_hold", fault_vaddr, 64'h4000_0123);

        // Fresh reset so replacement starts from an empty TLB and victim pointer 0.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst2.fault_vaddr", fault_vaddr, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("fill%0d", i), 64'h0041_0044 + 64'(i << 12), 3,
                      64'h8000_0000, 64'h8000_1010, 64'h8000_2080 + 64'(i * 8),
                      64'h9000_0044 + 64'(i << 12), 8, 1'b0);
        end
        run_check("rr.page1_hit", 64'h0041_1044, 0, 0, 0, 0, 64'h9000_1044, 2, 1'b0);
        run_check("rr.page0_miss", 64'h0041_0044, 3, 64'h8000_0000, 64'h8000_1010,
                  64'h8000_2080, 64'h9000_0044, 8, 1'b0);
        run_check("rr.page8_hit", 64'h0041_8044, 0, 0, 0, 0, 64'h9000_8044, 2, 1'b0);

        sfence = 1'b1;
        @(posedge clk);
        #1;
        sfence = 1'b0;
        run_check("sf.page8_miss", 64'h0041_8044, 3, 64'h8000_0000, 64'h8000_1010,
                  64'h8000_20C0, 64'h9000_8044, 8, 1'b0);

        fork
            run_check("sfwalk.page3", 64'h0041_3044, 3, 64'h8000_0000, 64'h8000_1010,
                      64'h8000_2098, 64'h9000_3044, 8, 1'b0);
            begin
                @(posedge clk);
                #1;
                sfence = 1'b1;
                @(posedge clk);
                #1;
                sfence = 1'b0;
            end
        join
        run_check("sfwalk.page3_again", 64'h0041_3044, 3, 64'h8000_0000, 64'h8000_1010,
                  64'h8000_2098, 64'h9000_3044, 8, 1'b0);
        run_check("sfwalk.page3_hit", 64'h0041_3044, 0, 0, 0, 0, 64'h9000_3044, 2, 1'b0);

        satp.asid = 16'd1;
        @(posedge clk);
        #1;
        run_check("satp.page3_miss", 64'h0041_3044, 3, 64'h8000_0000, 64'h8000_1010,
                  64'h8000_2098, 64'h9000_3044, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
